// File: rtl/dem_tree_scheduler.sv
// DEM-DAC switching-tree controller: range-checks samples, feeds the root block, aligns per-stage PN bits (DEM_SAT_CHECK_EN enables clamping).
// Latency: root_x/root_valid 1 cycle after accept, stage-s PN bits 1+s cycles, leaf_valid 1+STAGES cycles.
// Backpressure: sample_ready_o high only in RUN and dropped combinationally by stop_i; accepts one sample per cycle.
module dem_tree_scheduler #(
    parameter int          WIDTH  = 16,
    parameter int          STAGES = 3,
    parameter logic [14:0] SEED   = 15'h0001
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 sample_valid_i,
    input  logic [WIDTH-1:0]     sample_i,
    output logic                 sample_ready_o,
    output logic [WIDTH-1:0]     root_x_o,
    output logic                 root_valid_o,
    output logic [2**STAGES-2:0] pn_o,
    output logic                 leaf_valid_o,
    output logic                 busy_o,
    output logic                 sat_flag_o
);

    localparam int          NBLK       = 2**STAGES - 1;
    localparam logic [14:0] SEED_EFF   = (SEED == 15'd0) ? 15'h0001 : SEED;
    localparam logic [2:0]  FLUSH_LAST = 3'(STAGES);

    typedef enum logic [1:0] {ST_IDLE, ST_SEED, ST_RUN, ST_FLUSH} state_e;

    state_e             state_q, state_d;
    logic [2:0]         flush_cnt_q, flush_cnt_d;
    logic [14:0]        lfsr_q, lfsr_d;
    logic [WIDTH-1:0]   root_x_q, root_x_d;
    logic [STAGES:0]    vld_q, vld_d;
    logic [NBLK-1:0]    pn_dly_q [STAGES];
    logic [NBLK-1:0]    pn_dly_d [STAGES];
    logic [WIDTH-1:0]   sample_clamped;
    logic               seed_load;
    logic               accept;

    function automatic logic [NBLK-1:0] stage_mask(input int s);
        stage_mask = '0;
        for (int k = 0; k < NBLK; k++) begin
            if ((k + 1) >= (1 << s) && (k + 1) < (1 << (s + 1))) begin
                stage_mask[k] = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_SEED;
            ST_SEED:  state_d = ST_RUN;
            ST_RUN:   if (stop_i) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_cnt_q == FLUSH_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o         = (state_q != ST_IDLE);
        sample_ready_o = (state_q == ST_RUN) && !stop_i;
        seed_load      = (state_q == ST_SEED);
        accept         = sample_ready_o && sample_valid_i;
    end

`ifdef DEM_SAT_CHECK_EN
    localparam logic [WIDTH-1:0] MAX_CODE = WIDTH'(2**STAGES);

    logic sat_q, sat_d;
    logic clamp_hit;

    always_comb begin
        sample_clamped = sample_i;
        clamp_hit      = 1'b0;
        if (sample_i[WIDTH-1]) begin
            sample_clamped = '0;
            clamp_hit      = 1'b1;
        end else if ($signed(sample_i) > $signed(MAX_CODE)) begin
            sample_clamped = MAX_CODE;
            clamp_hit      = 1'b1;
        end
        sat_d = seed_load ? 1'b0 : (sat_q | (accept & clamp_hit));
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag_o = sat_q;
`else
    assign sample_clamped = sample_i;
    assign sat_flag_o     = 1'b0;
`endif

    // Stage 0 captures the pre-advance LFSR state; later stages shift it one cycle per tree level.
    always_comb begin
        flush_cnt_d = (state_q == ST_FLUSH) ? flush_cnt_q + 3'd1 : 3'd0;
        lfsr_d      = lfsr_q;
        if (seed_load) begin
            lfsr_d = SEED_EFF;
        end else if (accept) begin
            lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end
        root_x_d    = accept ? sample_clamped : root_x_q;
        vld_d       = {vld_q[STAGES-1:0], accept};
        pn_dly_d[0] = accept ? lfsr_q[NBLK-1:0] : pn_dly_q[0];
        for (int i = 1; i < STAGES; i++) begin
            pn_dly_d[i] = pn_dly_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            flush_cnt_q <= '0;
            lfsr_q      <= SEED_EFF;
            root_x_q    <= '0;
            vld_q       <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pn_dly_q[i] <= '0;
            end
        end else begin
            flush_cnt_q <= flush_cnt_d;
            lfsr_q      <= lfsr_d;
            root_x_q    <= root_x_d;
            vld_q       <= vld_d;
            for (int i = 0; i < STAGES; i++) begin
                pn_dly_q[i] <= pn_dly_d[i];
            end
        end
    end

    always_comb begin
        pn_o = '0;
        for (int s = 0; s < STAGES; s++) begin
            pn_o = pn_o | (pn_dly_q[s] & stage_mask(s));
        end
    end

    assign root_x_o     = root_x_q;
    assign root_valid_o = vld_q[0];
    assign leaf_valid_o = vld_q[STAGES];

endmodule

// File: doc/dem_tree_scheduler.md
# dem_tree_scheduler

Controller for the DEM-DAC switching tree. It accepts quantizer samples through a valid/ready handshake, range-checks them and issues each one to the root switching block. A 15-bit LFSR supplies one PN bit per switching block, and each stage's bits are delayed so that every stage of the registered tree uses the PN state of the sample it is currently processing. Leaf-aligned valid and busy status go to the unit-element driver.

## Interface
- WIDTH, 16: sample and tree datapath width, signed two's complement.
- STAGES, 3: tree depth. The tree has 2^STAGES unit elements and 2^STAGES-1 switching blocks. Legal range is 1..4.
- SEED, 15'h0001: LFSR load value. A value of 0 is replaced by 15'h0001.

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  pulse; starts a conversion run from IDLE.
- stop_i  in  1  pulse; ends the run and drains the tree.
- sample_valid_i  in  1  a sample is offered.
- sample_i  in  WIDTH  quantizer code; legal range 0..2^STAGES.
- sample_ready_o  out  1  the block can accept a sample (high only in RUN).
- root_x_o  out  WIDTH  x input to the root switching block.
- root_valid_o  out  1  root_x_o holds an accepted sample.
- pn_o  out  2^STAGES-1  PN bit per switching block, heap-indexed. Index 0 is the root; block k has children 2k+1 and 2k+2; block k is in stage floor(log2(k+1)).
- leaf_valid_o  out  1  the tree leaf outputs hold a valid sample.
- busy_o  out  1  state is not IDLE.
- sat_flag_o  out  1  sticky flag: an out-of-range sample was clamped.

## Operation
- FSM states: IDLE, SEED, RUN, FLUSH.
- IDLE: start_i moves to SEED. stop_i is ignored in IDLE.
- SEED: lasts one cycle. The LFSR is loaded with SEED, sat_flag_o is cleared, and the state moves to RUN.
- RUN: a sample is accepted when sample_valid_i is high (sample_ready_o is high throughout RUN).
  - stop_i moves to FLUSH.
  - stop_i takes priority: a sample offered in the same cycle as stop_i is not accepted, because sample_ready_o falls combinationally on stop_i.
  - start_i is ignored in RUN.
- FLUSH: lasts STAGES+1 cycles, counted by a flush counter. No samples are accepted. The state then returns to IDLE.
- LFSR: 15-bit Fibonacci, polynomial x^15+x^14+1. The feedback bit is s[14]^s[13] and is shifted into s[0].
  - The LFSR advances exactly once per accepted sample and holds otherwise.
  - The state S used for a sample is the value before that sample's advance.
- PN assignment: block k uses bit S[k]. The bits of stage s are delayed by s cycles through a per-stage register chain, so all blocks process one sample with one LFSR state.
- Range check: sample_i < 0 is clamped to 0 and sample_i > 2^STAGES is clamped to 2^STAGES. Either clamp sets sat_flag_o. The flag holds until the next SEED or until reset.
- Valid tracking: a STAGES+1 deep shift register of accept flags. Stage 0 drives root_valid_o; the last stage drives leaf_valid_o.
- Reset (asynchronous, while reset_i is low), mid-run included:
  - state goes to IDLE and the LFSR is loaded with SEED;
  - root_x_o, pn_o and every delay stage go to 0;
  - root_valid_o, leaf_valid_o, busy_o, sat_flag_o and sample_ready_o go to 0.
  - No partial sample survives reset.

## Timing
- Accept in cycle t gives:
  - cycle t+1: root_x_o and root_valid_o for that sample, with pn_o[0]=S[0];
  - cycle t+1+s: the stage-s bits of pn_o, that is S[2^s-1 .. 2^(s+1)-2];
  - cycle t+1+STAGES: leaf_valid_o high.
- Throughput is one sample per cycle. Back-to-back accepts give back-to-back leaf_valid_o, and each stage sees a distinct consecutive LFSR state.
- No accept in a cycle: root_valid_o goes low the next cycle. root_x_o and the pn stages hold their last values, so the held value is don't-care.
- Last accept at t, then stop_i at t+1: leaf_valid_o is high at t+1+STAGES. FLUSH ends after that, and busy_o falls at t+3+STAGES.
- A start_i-to-first-possible-accept path takes 2 cycles (IDLE→SEED→RUN).

## Configuration
- DEM_SAT_CHECK_EN defined: range clamping and sat_flag_o are implemented as described in Operation.
- DEM_SAT_CHECK_EN undefined:
  - sample_i passes unmodified to root_x_o;
  - sat_flag_o is tied to 0;
  - no comparator logic is built.
  - All other behaviour is identical.

## Test plan
- Reset and seed: hold reset_i low, then release; pulse start_i. Required: all outputs are 0 during reset; busy_o goes high; sample_ready_o goes high exactly 2 cycles after start_i.
- Latency and PN alignment (STAGES=3, SEED=1): accept 5, 3, 8 on consecutive cycles. Required:
  - root_x_o is 5, 3, 8 at t+1..t+3;
  - leaf_valid_o is high at t+4..t+6;
  - the sample-0 pn bits are S=15'h0001 (pn_o[0]=1, others 0) per stage at t+1, t+2 and t+3;
  - sample 1 uses S=15'h0002.
- LFSR hold: accept, skip 4 cycles, accept. Required: the second sample uses the next LFSR state, not one advanced by 5.
- Saturation (DEM_SAT_CHECK_EN defined, STAGES=3): drive sample_i = 12 and then -2. Required: root_x_o is 8 and then 0; sat_flag_o is high from the cycle after the first clamp and is cleared on the next start_i.
- Stop with collision: assert stop_i together with sample_valid_i in RUN. Required: that sample is not accepted; FLUSH lasts 4 cycles and busy_o then falls. With DEM_SAT_CHECK_EN undefined, sample 12 passes unclamped and sat_flag_o stays 0.
- Reset mid-run: assert reset_i low two cycles after an accept. Required: root_valid_o, leaf_valid_o and pn_o are 0 immediately. After release the state is IDLE and no stale leaf_valid_o appears.
